// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Raises a combinational stall toward the ID/EX registers while an operation is in flight.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_zero,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     msum, rem_sh, dtrial;
  logic [2*WIDTH-1:0] acc_step;

  // acc holds {partial product high, remaining multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; opnd holds a or b respectively.
  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    dtrial = rem_sh - {1'b0, opnd_q};
    if (!is_div_q)
      acc_step = {msum, acc_q[WIDTH-1:1]};
    else if (!dtrial[WIDTH])
      acc_step = {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (!flush && start && !op[1]) begin
          if (op[0] && operand_b == '0) begin
            state_d  = DONE;
            res_lo_d = '1;
            res_hi_d = operand_a;
            dbz_d    = 1'b1;
          end else begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH);
            is_div_d = op[0];
            opnd_d   = op[0] ? operand_b : operand_a;
            acc_d    = {{WIDTH{1'b0}}, (op[0] ? operand_a : operand_b)};
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d  = DONE;
            res_lo_d = acc_step[WIDTH-1:0];
            res_hi_d = acc_step[2*WIDTH-1:WIDTH];
            dbz_d    = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  // busy/stall are masked by rst so the pipeline never holds while reset is applied.
  assign busy        = !rst && (state_q != IDLE);
  assign stall       = !rst && ((state_q == RUN) || (state_q == IDLE && start && !op[1]));
  assign done        = (state_q == DONE);
  assign res_lo      = res_lo_q;
  assign res_hi      = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule
